sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, data bits per word; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 serial_in  input  1  serial data bit, sampled only when serial_valid=1.
REQ-005 serial_valid  input  1  bit strobe; one bit is consumed per clk edge with serial_valid=1.
REQ-006 frame_start  input  1  qualified by serial_valid; marks the current bit as the first (MSB) of a new word.
REQ-007 parallel_out  output  WIDTH  assembled word, bit WIDTH-1 = first bit received.
REQ-008 out_valid  output  1  parallel_out holds an undelivered word.
REQ-009 out_ready  input  1  consumer accepts the word at a clk edge where out_valid=1 and out_ready=1.
REQ-010 overrun  output  1  one-cycle pulse when a completed word replaces an unaccepted one.
REQ-011 parity_err  output  1  parity status of the word in parallel_out; valid only while out_valid=1.

Function
REQ-012 FSM states: IDLE, SHIFT, PARITY; PARITY is reachable only with the parity feature compiled in.
REQ-013 IDLE: bits with serial_valid=1 and frame_start=0 are discarded; serial_valid=1 with frame_start=1 shifts the bit in, sets bit count to 1, and moves to SHIFT.
REQ-014 SHIFT: each qualified bit shifts in MSB-first and increments a count of width clog2(WIDTH+1).
REQ-015 Completion (WIDTH-th bit, no parity): at the same edge, load parallel_out, set out_valid=1, and return to IDLE; out_valid is visible 1 cycle after the last bit is sampled.
REQ-016 A cycle with serial_valid=0 holds all shift state; there is no timeout.
REQ-017 serial_valid=1 with frame_start=1 in SHIFT or PARITY aborts the partial word without output and restarts the frame with this bit as the first bit.
REQ-018 out_valid clears at an edge where out_ready=1, unless a new word completes at that same edge.
REQ-019 New word completes while out_valid=1 and out_ready=0: the new word overwrites parallel_out, out_valid stays 1, and overrun pulses high for exactly 1 cycle.
REQ-020 New word completes while out_valid=1 and out_ready=1: the old word is accepted, the new word loads, out_valid stays 1, and overrun stays 0.
REQ-021 parallel_out is stable whenever out_valid=1, except at a load edge.

Reset
REQ-022 rst=1 immediately forces: FSM=IDLE, count=0, shift register=0, parallel_out=0, out_valid=0, overrun=0, parity_err=0.
REQ-023 Reset mid-word discards the partial word; after reset release, reception resumes only at the next frame_start.

Configuration
REQ-024 SIPO_PARITY_EN defined: after the WIDTH-th data bit, the FSM enters PARITY and the next qualified bit is an even-parity bit.
REQ-025 In PARITY, the word completes on the parity bit, with the REQ-015 latency measured from the parity bit.
REQ-026 parity_err loads with parallel_out; parity_err = XOR of all data bits and the parity bit.
REQ-027 SIPO_PARITY_EN undefined: no PARITY state, no parity logic, and parity_err is tied to 0; the port list is identical in both builds.

Structure
REQ-028 Package sipo_pkg holds the state enum typedef (IDLE/SHIFT/PARITY) and constant SIPO_DEFAULT_WIDTH=4.
REQ-029 One sub-module, sipo_shift_core, contains the shift register and bit counter with shift/clear controls; the FSM, output register and handshake stay in sipo_deserializer.

Verification (WIDTH=4, parity off unless stated)
REQ-030 Stimulus: frame_start on first bit, bits 1,0,1,0 on consecutive cycles, out_ready=1. Response: parallel_out=4'b1010 with out_valid=1 for exactly 1 cycle, 1 cycle after the 4th bit; then 1,1,0,0 gives 4'b1100.
REQ-031 Stimulus: 1010, out_ready=0, then 0110 completes. Response: overrun pulses 1 cycle, parallel_out=4'b0110, out_valid stays 1; raising out_ready clears out_valid at the next edge.
REQ-032 Stimulus: bits 1,1 then frame_start with bits 0,0,1,1. Response: the only output is 4'b0011; no 4'b11xx word appears.
REQ-033 Stimulus: bits 1,0 then rst pulsed asynchronously between edges, then a full frame 0101. Response: all outputs read 0 during reset; the next word is 4'b0101.
REQ-034 Stimulus: serial_valid gaps of 3 cycles between bits of 1001. Response: parallel_out=4'b1001, 1 cycle after the last bit.
REQ-035 Stimulus: SIPO_PARITY_EN build, data 1011 with parity 1, then data 1011 with parity 0. Response: parity_err=0 on the first word and 1 on the second, each with out_valid.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter; start loads the first bit, shift appends MSB-first, clear zeroes both.
// Latency: state updates on the edge that qualifies the control.
// Backpressure: none, the controller decides when bits are consumed.
module sipo_shift_core #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] shreg_o,
    output logic [CW-1:0]    cnt_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (start_i) begin
            shreg_d = {{(WIDTH-1){1'b0}}, bit_i};
            cnt_d   = CW'(1);
        end else if (shift_i) begin
            shreg_d = WIDTH'({shreg_q, bit_i});
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shreg_o = shreg_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel word assembler, MSB first; SIPO_PARITY_EN adds a trailing even-parity bit.
// Latency: word visible one cycle after its last bit (data or parity) is sampled.
// Backpressure: none on the serial side; an unaccepted word is overwritten and overrun pulses.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic             core_start, core_shift, core_clear;
    logic             word_done;
    logic [WIDTH-1:0] word_dat;

    logic [WIDTH-1:0] parallel_q, parallel_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (core_start),
        .shift_i (core_shift),
        .clear_i (core_clear),
        .bit_i   (serial_in),
        .shreg_o (shreg),
        .cnt_o   (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (serial_valid && frame_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (serial_valid && !frame_start && cnt == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                if (serial_valid) state_d = frame_start ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A frame_start bit restarts the frame from any state, dropping any partial word.
    always_comb begin
        core_start = serial_valid && frame_start;
        core_shift = serial_valid && !frame_start && (state_q == SHIFT);
`ifdef SIPO_PARITY_EN
        word_done  = serial_valid && !frame_start && (state_q == PARITY);
        word_dat   = shreg;
`else
        word_done  = core_shift && (cnt == LAST_CNT);
        word_dat   = WIDTH'({shreg, serial_in});
`endif
        core_clear = word_done;
    end

    always_comb begin
        parallel_d  = parallel_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (word_done) begin
            parallel_d  = word_dat;
            out_valid_d = 1'b1;
        end
        overrun_d = word_done && out_valid_q && !out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            parallel_q  <= parallel_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Even parity: XOR over data plus parity bit is zero for a clean word.
    always_comb begin
        parity_err_d = parity_err_q;
        if (word_done) parity_err_d = (^shreg) ^ serial_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign parallel_out = parallel_q;
    assign out_valid    = out_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=4); a scoreboard queue is checked by a negedge monitor.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         serial_valid;
    logic         frame_start;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         parity_err;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic         ovr;
        logic         perr;
        int           due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: a word is newly presented when valid rises, follows an accepted word, or overruns.
    logic prev_vld = 1'b0;
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (out_valid && (!prev_vld || prev_rdy || overrun)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %b, expected no word (cycle %0d)", parallel_out, cyc);
                end else begin
                    e = q.pop_front();
                    check("word", 32'(parallel_out), 32'(e.word));
                    check("overrun", 32'(overrun), 32'(e.ovr));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                    check("latency_cycle", 32'(cyc), 32'(e.due));
                end
            end
            prev_vld = out_valid;
            prev_rdy = out_ready;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        serial_valid = 1'b1;
        serial_in    = b;
        frame_start  = fs;
        @(posedge clk);
        #1;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        serial_in    = 1'b0;
    endtask

    // Sends a data word MSB first; the parity build appends an even-parity bit, flipped by inject.
    task automatic send_word(input logic [W-1:0] w, input int gap, input logic inject);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], i == W - 1);
            if (i != 0) idle(gap);
        end
`ifdef SIPO_PARITY_EN
        idle(gap);
        send_bit((^w) ^ inject, 1'b0);
`endif
    endtask

    task automatic push_exp(input logic [W-1:0] w, input logic ovr, input logic inject);
        exp_t e;
        e.word = w;
        e.ovr  = ovr;
`ifdef SIPO_PARITY_EN
        e.perr = inject;
`else
        e.perr = 1'b0;
`endif
        e.due  = cyc;
        q.push_back(e);
    endtask

    initial begin
        rst          = 1'b1;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        out_ready    = 1'b1;
        idle(2);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_parallel_out", 32'(parallel_out), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_parity_err", 32'(parity_err), 0);
        rst = 1'b0;
        idle(1);

        // Basic frames with a ready consumer: valid lasts exactly one cycle.
        send_word(4'b1010, 0, 1'b0);
        push_exp(4'b1010, 1'b0, 1'b0);
        check("t1_valid_after_last_bit", 32'(out_valid), 1);
        idle(1);
        check("t1_valid_one_cycle", 32'(out_valid), 0);
        send_word(4'b1100, 0, 1'b0);
        push_exp(4'b1100, 1'b0, 1'b0);
        idle(2);

        // Overrun: second word replaces an unaccepted first word.
        out_ready = 1'b0;
        send_word(4'b1010, 0, 1'b0);
        push_exp(4'b1010, 1'b0, 1'b0);
        idle(2);
        check("t2_held_valid", 32'(out_valid), 1);
        check("t2_held_word", 32'(parallel_out), 32'(4'b1010));
        send_word(4'b0110, 0, 1'b0);
        push_exp(4'b0110, 1'b1, 1'b0);
        check("t2_overrun_pulse", 32'(overrun), 1);
        idle(1);
        check("t2_overrun_one_cycle", 32'(overrun), 0);
        check("t2_valid_stays", 32'(out_valid), 1);
        check("t2_word_stable", 32'(parallel_out), 32'(4'b0110));
        out_ready = 1'b1;
        idle(1);
        check("t2_valid_cleared", 32'(out_valid), 0);

        // Accept and load on the same edge: no overrun, valid stays up.
        out_ready = 1'b0;
        send_word(4'b1110, 0, 1'b0);
        push_exp(4'b1110, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b1, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
`else
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
`endif
        push_exp(4'b0001, 1'b0, 1'b0);
        check("t6_no_overrun", 32'(overrun), 0);
        check("t6_valid_stays", 32'(out_valid), 1);
        idle(1);
        check("t6_valid_cleared", 32'(out_valid), 0);

        // Abort: a frame_start mid-word restarts without emitting 11xx.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_word(4'b0011, 0, 1'b0);
        push_exp(4'b0011, 1'b0, 1'b0);
        idle(2);

        // Asynchronous reset mid-word while a word is still held.
        out_ready = 1'b0;
        send_word(4'b1111, 0, 1'b0);
        push_exp(4'b1111, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t4_reset_out_valid", 32'(out_valid), 0);
        check("t4_reset_parallel_out", 32'(parallel_out), 0);
        check("t4_reset_overrun", 32'(overrun), 0);
        check("t4_reset_parity_err", 32'(parity_err), 0);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_word(4'b0101, 0, 1'b0);
        push_exp(4'b0101, 1'b0, 1'b0);
        idle(2);

        // Gaps of three idle cycles between bits.
        send_word(4'b1001, 3, 1'b0);
        push_exp(4'b1001, 1'b0, 1'b0);
        idle(2);

`ifdef SIPO_PARITY_EN
        send_word(4'b1011, 0, 1'b0);
        push_exp(4'b1011, 1'b0, 1'b0);
        idle(2);
        send_word(4'b1011, 0, 1'b1);
        push_exp(4'b1011, 1'b0, 1'b1);
        idle(2);
`endif

        idle(5);
        check("scoreboard_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
